onn_sequencer: RTL and testbench

Network-level controller that sits directly upstream of every `neuron` instance in the oscillatory neural network. It loads the initial phase pattern into the neurons, generates the per-oscillation-period `full_tick` and `state_cheak` strobes, and freezes phase updates with `drop` outside the run window. It also collects the per-neuron `state_changed` flags to declare convergence, or a timeout if convergence is not reached.

---
 rtl/onn_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_onn_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/onn_sequencer.sv
// Network-level sequencer for the oscillatory neural network: loads the initial
// phase pattern, produces per-period full_tick/state_cheak strobes, gates phase
// updates with drop outside the run window and detects convergence or timeout.
module onn_sequencer #(
  parameter int unsigned N              = 4,
  parameter int unsigned PERIOD         = 16,
  parameter int unsigned STABLE_PERIODS = 3,
  parameter int unsigned MAX_PERIODS    = 64
) (
  input  logic           i_sclk,
  input  logic           i_re_n,
  input  logic           i_start,
  input  logic           i_abort,
  input  logic [4*N-1:0] i_pattern_in,
  input  logic [N-1:0]   i_state_changed,
  output logic           o_load,
  output logic [4*N-1:0] o_ini_phase,
  output logic           o_full_tick,
  output logic           o_state_cheak,
  output logic           o_drop,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_converged,
  output logic           o_timeout,
  output logic [7:0]     o_period_cnt
);

  localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] TickLast  = TW'(PERIOD - 1);
  // full_tick is registered, so it is armed one tick early
  localparam logic [TW-1:0] TickPre   = TW'(PERIOD - 2);
  localparam logic [7:0]    StableTgt = 8'(STABLE_PERIODS);
  localparam logic [7:0]    MaxTgt    = 8'(MAX_PERIODS);

  typedef enum logic [2:0] {
    StIdle, StLoad, StRun, StChk, StSample, StDone
  } state_e;

  state_e         r_state;
  logic [1:0]     r_rst_sync;
  logic           w_rst_n;
  logic           r_start;
  logic [4*N-1:0] r_pattern;
  logic           r_load_cnt;
  logic [TW-1:0]  r_tick;
  logic [7:0]     r_stable;
  logic           w_any;
  logic [7:0]     w_stable_next;
  logic           w_launch_ok;

  // Asynchronous assertion, synchronised deassertion of the internal reset
  always_ff @(posedge i_sclk or negedge i_re_n) begin
    if (!i_re_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n       = r_rst_sync[1];
  assign w_launch_ok   = (r_state == StIdle) || (r_state == StDone);
  assign w_any         = |i_state_changed;
  assign w_stable_next = w_any ? 8'd0 : (r_stable + 8'd1);

  // Capture a start request; abort in the same cycle cancels it
  always_ff @(posedge i_sclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_start   <= 1'b0;
      r_pattern <= '0;
    end else begin
      r_start <= i_start & ~i_abort & w_launch_ok;
      if (i_start && !i_abort && w_launch_ok) begin
        r_pattern <= i_pattern_in;
      end
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge i_sclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= StIdle;
      r_load_cnt    <= 1'b0;
      r_tick        <= '0;
      r_stable      <= 8'd0;
      o_load        <= 1'b0;
      o_ini_phase   <= '0;
      o_full_tick   <= 1'b0;
      o_state_cheak <= 1'b0;
      o_drop        <= 1'b1;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_converged   <= 1'b0;
      o_timeout     <= 1'b0;
      o_period_cnt  <= 8'd0;
    end else if (i_abort) begin
      r_state       <= StIdle;
      r_load_cnt    <= 1'b0;
      r_tick        <= '0;
      r_stable      <= 8'd0;
      o_load        <= 1'b0;
      o_full_tick   <= 1'b0;
      o_state_cheak <= 1'b0;
      o_drop        <= 1'b1;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_converged   <= 1'b0;
      o_timeout     <= 1'b0;
      o_period_cnt  <= 8'd0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (r_start) begin
            r_state      <= StLoad;
            r_load_cnt   <= 1'b0;
            r_tick       <= '0;
            r_stable     <= 8'd0;
            o_ini_phase  <= r_pattern;
            o_period_cnt <= 8'd0;
            o_converged  <= 1'b0;
            o_timeout    <= 1'b0;
            o_done       <= 1'b0;
            o_load       <= 1'b1;
            o_busy       <= 1'b1;
            o_drop       <= 1'b1;
          end
        end
        StLoad: begin
          if (r_load_cnt) begin
            r_state <= StRun;
            r_tick  <= '0;
            o_load  <= 1'b0;
            o_drop  <= 1'b0;
          end else begin
            r_load_cnt <= 1'b1;
          end
        end
        StRun: begin
          o_full_tick <= (r_tick == TickPre);
          if (r_tick == TickLast) begin
            r_tick        <= '0;
            o_period_cnt  <= o_period_cnt + 8'd1;
            o_state_cheak <= 1'b1;
            r_state       <= StChk;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        StChk: begin
          // Tick keeps running so each period stays exactly PERIOD cycles
          r_tick        <= r_tick + 1'b1;
          o_state_cheak <= 1'b0;
          r_state       <= StSample;
        end
        StSample: begin
          r_tick   <= r_tick + 1'b1;
          r_stable <= w_stable_next;
          if (w_stable_next == StableTgt) begin
            o_converged <= 1'b1;
            o_done      <= 1'b1;
            o_busy      <= 1'b0;
            o_drop      <= 1'b1;
            r_state     <= StDone;
          end else if (o_period_cnt == MaxTgt) begin
            o_timeout <= 1'b1;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            o_drop    <= 1'b1;
            r_state   <= StDone;
          end else begin
            r_state <= StRun;
          end
        end
        default: begin
          r_state <= StIdle;
          o_drop  <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onn_sequencer.sv
// Bench for onn_sequencer: three instances (default, MAX_PERIODS=8,
// MAX_PERIODS=3) share clock and reset; a scoreboard checks each run result.
module tb_onn_sequencer;

  logic clk = 1'b0;
  logic re_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        conv;
    logic        tmo;
    logic [7:0]  pc;
    logic [15:0] ini;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  logic        start_a = 0, start_b = 0, start_c = 0;
  logic        abort_a = 0, abort_b = 0, abort_c = 0;
  logic [15:0] pat_a = 0, pat_b = 0, pat_c = 0;
  logic [3:0]  sc_a = 0, sc_b = 0, sc_c = 0;

  logic        load_a, ft_a, sk_a, drop_a, busy_a, done_a, conv_a, tmo_a;
  logic        load_b, ft_b, sk_b, drop_b, busy_b, done_b, conv_b, tmo_b;
  logic        load_c, ft_c, sk_c, drop_c, busy_c, done_c, conv_c, tmo_c;
  logic [15:0] ini_a, ini_b, ini_c;
  logic [7:0]  pc_a, pc_b, pc_c;

  onn_sequencer #(.N(4), .PERIOD(16), .STABLE_PERIODS(3), .MAX_PERIODS(64)) u_a (
    .i_sclk(clk), .i_re_n(re_n), .i_start(start_a), .i_abort(abort_a),
    .i_pattern_in(pat_a), .i_state_changed(sc_a), .o_load(load_a), .o_ini_phase(ini_a),
    .o_full_tick(ft_a), .o_state_cheak(sk_a), .o_drop(drop_a), .o_busy(busy_a),
    .o_done(done_a), .o_converged(conv_a), .o_timeout(tmo_a), .o_period_cnt(pc_a)
  );

  onn_sequencer #(.N(4), .PERIOD(16), .STABLE_PERIODS(3), .MAX_PERIODS(8)) u_b (
    .i_sclk(clk), .i_re_n(re_n), .i_start(start_b), .i_abort(abort_b),
    .i_pattern_in(pat_b), .i_state_changed(sc_b), .o_load(load_b), .o_ini_phase(ini_b),
    .o_full_tick(ft_b), .o_state_cheak(sk_b), .o_drop(drop_b), .o_busy(busy_b),
    .o_done(done_b), .o_converged(conv_b), .o_timeout(tmo_b), .o_period_cnt(pc_b)
  );

  onn_sequencer #(.N(4), .PERIOD(16), .STABLE_PERIODS(3), .MAX_PERIODS(3)) u_c (
    .i_sclk(clk), .i_re_n(re_n), .i_start(start_c), .i_abort(abort_c),
    .i_pattern_in(pat_c), .i_state_changed(sc_c), .o_load(load_c), .o_ini_phase(ini_c),
    .o_full_tick(ft_c), .o_state_cheak(sk_c), .o_drop(drop_c), .o_busy(busy_c),
    .o_done(done_c), .o_converged(conv_c), .o_timeout(tmo_c), .o_period_cnt(pc_c)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Neuron models: the period index is period_cnt+1 while full_tick is high.
  // A changes in periods 1-2 only, B always changes (toggling), C never does.
  always @(negedge clk) begin
    if (ft_a) sc_a = (pc_a < 8'd2) ? 4'b0010 : 4'b0000;
    if (ft_b) sc_b = pc_b[0] ? 4'b0101 : 4'b1010;
  end

  // Scoreboard monitors: pop and compare on each rising edge of done
  logic pd_a = 0, pd_b = 0, pd_c = 0;
  exp_t e_a, e_b, e_c;

  always @(negedge clk) begin
    if (done_a && !pd_a) begin
      if (q_a.size() == 0) chk("a_unexpected_done", 32'd1, 32'd0);
      else begin
        e_a = q_a.pop_front();
        chk("a_converged", conv_a, e_a.conv);
        chk("a_timeout", tmo_a, e_a.tmo);
        chk("a_period_cnt", pc_a, e_a.pc);
        chk("a_ini_phase", ini_a, e_a.ini);
      end
    end
    pd_a <= done_a;
  end

  always @(negedge clk) begin
    if (done_b && !pd_b) begin
      if (q_b.size() == 0) chk("b_unexpected_done", 32'd1, 32'd0);
      else begin
        e_b = q_b.pop_front();
        chk("b_converged", conv_b, e_b.conv);
        chk("b_timeout", tmo_b, e_b.tmo);
        chk("b_period_cnt", pc_b, e_b.pc);
        chk("b_ini_phase", ini_b, e_b.ini);
      end
    end
    pd_b <= done_b;
  end

  always @(negedge clk) begin
    if (done_c && !pd_c) begin
      if (q_c.size() == 0) chk("c_unexpected_done", 32'd1, 32'd0);
      else begin
        e_c = q_c.pop_front();
        chk("c_converged", conv_c, e_c.conv);
        chk("c_timeout", tmo_c, e_c.tmo);
        chk("c_period_cnt", pc_c, e_c.pc);
        chk("c_ini_phase", ini_c, e_c.ini);
      end
    end
    pd_c <= done_c;
  end

  initial begin
    int n;
    logic bad;

    repeat (3) @(negedge clk);
    re_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_drop", drop_a, 1'b1);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_load", load_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_ini_phase", ini_a, 16'h0000);
    chk("rst_period_cnt", pc_a, 8'd0);

    // Launch all three instances together
    pat_a = 16'hC840; pat_b = 16'hA5A5; pat_c = 16'h0F0F;
    start_a = 1; start_b = 1; start_c = 1;
    q_a.push_back('{conv: 1'b1, tmo: 1'b0, pc: 8'd5, ini: 16'hC840});
    q_b.push_back('{conv: 1'b0, tmo: 1'b1, pc: 8'd8, ini: 16'hA5A5});
    q_c.push_back('{conv: 1'b1, tmo: 1'b0, pc: 8'd3, ini: 16'h0F0F});
    @(posedge clk);
    @(negedge clk);
    start_a = 0; start_b = 0; start_c = 0;
    chk("load_after_k", load_a, 1'b0);
    @(negedge clk);
    chk("load_after_k1", load_a, 1'b1);
    chk("busy_after_k1", busy_a, 1'b1);
    chk("ini_after_k1", ini_a, 16'hC840);
    chk("drop_in_load", drop_a, 1'b1);
    @(negedge clk);
    chk("load_after_k2", load_a, 1'b1);
    @(negedge clk);
    chk("load_after_k3", load_a, 1'b0);
    chk("drop_in_run", drop_a, 1'b0);
    n = 0;
    while (!ft_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_full_tick_delay", n, 32'd15);
    @(negedge clk);
    chk("state_cheak_after_tick", sk_a, 1'b1);
    chk("full_tick_one_cycle", ft_a, 1'b0);
    chk("period_cnt_first", pc_a, 8'd1);

    n = 0;
    while (!(done_a && done_b && done_c) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("all_done_in_time", (n < 400), 1'b1);
    @(negedge clk);
    chk("a_converged_held", conv_a, 1'b1);
    chk("a_drop_in_done", drop_a, 1'b1);
    chk("a_busy_in_done", busy_a, 1'b0);

    // Restart A from DONE with a new pattern
    pat_a = 16'h1234;
    start_a = 1;
    @(posedge clk);
    @(negedge clk);
    start_a = 0;
    @(negedge clk);
    chk("relaunch_load", load_a, 1'b1);
    chk("relaunch_ini", ini_a, 16'h1234);
    chk("relaunch_done_clr", done_a, 1'b0);
    chk("relaunch_conv_clr", conv_a, 1'b0);
    n = 0;
    while (!ft_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("relaunch_full_tick_seen", ft_a, 1'b1);
    // Abort on the edge that would enter CHK; start alongside must be ignored
    abort_a = 1; start_a = 1;
    @(posedge clk);
    @(negedge clk);
    abort_a = 0; start_a = 0;
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_period_cnt", pc_a, 8'd0);
    chk("abort_no_state_cheak", sk_a, 1'b0);
    chk("abort_drop", drop_a, 1'b1);
    chk("abort_ini_held", ini_a, 16'h1234);

    // Abort and start together in IDLE: no launch
    abort_a = 1; start_a = 1;
    @(posedge clk);
    @(negedge clk);
    abort_a = 0; start_a = 0;
    bad = 1'b0;
    repeat (5) begin
      if (load_a || busy_a || sk_a) bad = 1'b1;
      @(negedge clk);
    end
    chk("abort_start_ignored", bad, 1'b0);

    // Reset asserted mid-run
    pat_a = 16'h5555;
    start_a = 1;
    @(posedge clk);
    @(negedge clk);
    start_a = 0;
    repeat (25) @(negedge clk);
    chk("midrun_pc_nonzero", (pc_a != 8'd0), 1'b1);
    re_n = 1'b0;
    #1;
    chk("midrun_rst_drop", drop_a, 1'b1);
    chk("midrun_rst_busy", busy_a, 1'b0);
    chk("midrun_rst_pc", pc_a, 8'd0);
    chk("midrun_rst_ini", ini_a, 16'h0000);
    chk("midrun_rst_strobes", {load_a, ft_a, sk_a, done_a, conv_a, tmo_a}, 6'b0);
    chk("midrun_rst_b_done", done_b, 1'b0);
    repeat (2) @(negedge clk);
    re_n = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!drop_a || busy_a || load_a) bad = 1'b1;
    end
    chk("idle_hold_after_reset", bad, 1'b0);

    chk("queue_a_empty", q_a.size(), 32'd0);
    chk("queue_b_empty", q_b.size(), 32'd0);
    chk("queue_c_empty", q_c.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
